// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 phase sequencer and its memory mux.
// Defines the phase enum, S-memory geometry and the per-engine request bundle.
// No logic; imported by the interface, the mux and the sequencer top.
package rc4_pkg;

   localparam int S_DEPTH     = 256;
   localparam int ADDR_W      = 8;
   localparam int DATA_W      = 8;
   localparam int ERST_CYCLES = 2;

   typedef enum logic [2:0] {
      IDLE,
      ERST,
      INIT,
      KSA,
      PRGA,
      DONE,
      ERR
   } phase_t;

   // One engine's request to the single-port S-memory.
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wrdata;
      logic              wren;
   } mem_req_t;

endpackage

// File: rtl/rc4_phase_sched_if.sv
// Engine/memory bus of the RC4 sequencer.
// master: sequencer side (drives go enables and S-memory port, receives done flags,
// engine memory requests and the host read address). slave: engines, memory and host.
interface rc4_phase_sched_if;
   import rc4_pkg::*;

   logic              init_go,   ksa_go,   prga_go;
   logic              init_done, ksa_done, prga_done;

   logic [ADDR_W-1:0] init_addr,   ksa_addr,   prga_addr;
   logic [DATA_W-1:0] init_wrdata, ksa_wrdata, prga_wrdata;
   logic              init_wren,   ksa_wren,   prga_wren;

   logic [ADDR_W-1:0] host_addr;

   logic [ADDR_W-1:0] s_addr;
   logic [DATA_W-1:0] s_wrdata;
   logic              s_wren;

   modport master (
      output init_go, ksa_go, prga_go,
      input  init_done, ksa_done, prga_done,
      input  init_addr, init_wrdata, init_wren,
      input  ksa_addr,  ksa_wrdata,  ksa_wren,
      input  prga_addr, prga_wrdata, prga_wren,
      input  host_addr,
      output s_addr, s_wrdata, s_wren
   );

   modport slave (
      input  init_go, ksa_go, prga_go,
      output init_done, ksa_done, prga_done,
      output init_addr, init_wrdata, init_wren,
      output ksa_addr,  ksa_wrdata,  ksa_wren,
      output prga_addr, prga_wrdata, prga_wren,
      output host_addr,
      input  s_addr, s_wrdata, s_wren
   );

endinterface

// File: rtl/rc4_mem_mux.sv
// S-memory port mux: grants the single-port S-memory to the engine owning the phase.
// Ports: state (select), init/ksa/prga request bundles, host_addr in; s_addr/s_wrdata/s_wren out.
// Purely combinational, zero latency; non-selected write enables never reach the memory.
module rc4_mem_mux
   import rc4_pkg::*;
(
   input  phase_t            state,
   input  mem_req_t          init_req,
   input  mem_req_t          ksa_req,
   input  mem_req_t          prga_req,
   input  logic [ADDR_W-1:0] host_addr,
   output logic [ADDR_W-1:0] s_addr,
   output logic [DATA_W-1:0] s_wrdata,
   output logic              s_wren
);

   always_comb begin
      // Host read port owns the memory whenever no engine does.
      s_addr   = host_addr;
      s_wrdata = '0;
      s_wren   = 1'b0;
      case (state)
         ERST: begin
            s_addr = '0;
         end
         INIT: begin
            s_addr   = init_req.addr;
            s_wrdata = init_req.wrdata;
            s_wren   = init_req.wren;
         end
         KSA: begin
            s_addr   = ksa_req.addr;
            s_wrdata = ksa_req.wrdata;
            s_wren   = ksa_req.wren;
         end
         PRGA: begin
            s_addr   = prga_req.addr;
            s_wrdata = prga_req.wrdata;
            s_wren   = prga_req.wren;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/rc4_phase_sched.sv
// RC4 decrypt sequencer: runs init, KSA, PRGA engines in order, owns the S-memory mux,
// lends memory to the host when idle, and aborts a phase that exceeds TIMEOUT cycles.
// Ports: clk/rst_n, start/key_in, busy/done/error/key_out/eng_rst_n status, bus (master).
module rc4_phase_sched
   import rc4_pkg::*;
#(
   parameter int TIMEOUT = 4096,
   parameter int KEY_W   = 24
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [KEY_W-1:0]   key_in,
   output logic               busy,
   output logic               done,
   output logic               error,
   output logic [KEY_W-1:0]   key_out,
   output logic               eng_rst_n,
   rc4_phase_sched_if.master  bus
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] ERST_LAST = CNT_W'(ERST_CYCLES - 1);

   phase_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [KEY_W-1:0]   key_q, key_d;
   logic               eng_rst_n_q, eng_rst_n_d;
   logic               done_q, done_d;
   logic               error_q, error_d;
   logic               phase_done;
   phase_t             phase_next;

   // Only the engine that owns the current phase may advance the sequence.
   always_comb begin
      phase_done = 1'b0;
      phase_next = state_q;
      case (state_q)
         INIT: begin
            phase_done = bus.init_done;
            phase_next = KSA;
         end
         KSA: begin
            phase_done = bus.ksa_done;
            phase_next = PRGA;
         end
         PRGA: begin
            phase_done = bus.prga_done;
            phase_next = DONE;
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      key_d   = key_q;
      case (state_q)
         IDLE, DONE, ERR: begin
            if (start) begin
               state_d = ERST;
               cnt_d   = '0;
               key_d   = key_in;
            end
         end
         ERST: begin
            // The phase counter doubles as the engine-reset stretch timer.
            if (cnt_q == ERST_LAST) begin
               state_d = INIT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         INIT, KSA, PRGA: begin
            // Done wins over a coincident watchdog expiry.
            if (phase_done) begin
               state_d = phase_next;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ERR;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      // Engines are held in reset while being restarted and after an abort.
      eng_rst_n_d = !((state_d == ERST) || (state_d == ERR));
      done_d      = (state_d == DONE);
      error_d     = (state_d == ERR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         key_q       <= '0;
         eng_rst_n_q <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         key_q       <= key_d;
         eng_rst_n_q <= eng_rst_n_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   assign busy      = (state_q == ERST) || (state_q == INIT) ||
                      (state_q == KSA)  || (state_q == PRGA);
   assign done      = done_q;
   assign error     = error_q;
   assign key_out   = key_q;
   assign eng_rst_n = eng_rst_n_q;

   // Enables are cumulative so finished engines stay parked in their done state.
   assign bus.init_go = (state_q == INIT) || (state_q == KSA) ||
                        (state_q == PRGA) || (state_q == DONE);
   assign bus.ksa_go  = (state_q == KSA)  || (state_q == PRGA) || (state_q == DONE);
   assign bus.prga_go = (state_q == PRGA) || (state_q == DONE);

   mem_req_t init_req, ksa_req, prga_req;

   assign init_req = '{addr: bus.init_addr, wrdata: bus.init_wrdata, wren: bus.init_wren};
   assign ksa_req  = '{addr: bus.ksa_addr,  wrdata: bus.ksa_wrdata,  wren: bus.ksa_wren};
   assign prga_req = '{addr: bus.prga_addr, wrdata: bus.prga_wrdata, wren: bus.prga_wren};

   rc4_mem_mux u_mem_mux (
      .state     (state_q),
      .init_req  (init_req),
      .ksa_req   (ksa_req),
      .prga_req  (prga_req),
      .host_addr (bus.host_addr),
      .s_addr    (bus.s_addr),
      .s_wrdata  (bus.s_wrdata),
      .s_wren    (bus.s_wren)
   );

endmodule

// File: tb/tb_rc4_phase_sched.sv
// Bench for rc4_phase_sched: stub engines driven from tasks, write-count memory model,
// a default-TIMEOUT instance for full runs and a TIMEOUT=64 instance for watchdog cases.
// Expected values come from phase timelines (2-cycle engine reset, chosen done delays).
module tb_rc4_phase_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, start2;
   logic [23:0] key_in, key_in2;
   logic        busy, done, error, eng_rst_n;
   logic        busy2, done2, error2, eng_rst_n2;
   logic [23:0] key_out, key_out2;

   int n_checks = 0;
   int n_fail   = 0;
   int wr7 = 0, wr5 = 0, wr33 = 0;

   always #5 clk = ~clk;

   rc4_phase_sched_if bus ();
   rc4_phase_sched_if bus2 ();

   rc4_phase_sched #(.TIMEOUT(4096), .KEY_W(24)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
      .busy(busy), .done(done), .error(error), .key_out(key_out),
      .eng_rst_n(eng_rst_n), .bus(bus)
   );

   rc4_phase_sched #(.TIMEOUT(64), .KEY_W(24)) dut_t (
      .clk(clk), .rst_n(rst_n), .start(start2), .key_in(key_in2),
      .busy(busy2), .done(done2), .error(error2), .key_out(key_out2),
      .eng_rst_n(eng_rst_n2), .bus(bus2)
   );

   // Stub engines: each requests a write to its own address every cycle.
   assign bus.init_addr   = 8'h07;
   assign bus.init_wrdata = 8'hA7;
   assign bus.init_wren   = 1'b1;
   assign bus.ksa_addr    = 8'h05;
   assign bus.ksa_wrdata  = 8'h55;
   assign bus.ksa_wren    = 1'b1;
   assign bus.prga_addr   = 8'h33;
   assign bus.prga_wrdata = 8'hC3;
   assign bus.prga_wren   = 1'b1;

   assign bus2.init_addr   = 8'h00;
   assign bus2.init_wrdata = 8'h00;
   assign bus2.init_wren   = 1'b0;
   assign bus2.ksa_addr    = 8'h00;
   assign bus2.ksa_wrdata  = 8'h00;
   assign bus2.ksa_wren    = 1'b0;
   assign bus2.prga_addr   = 8'h00;
   assign bus2.prga_wrdata = 8'h00;
   assign bus2.prga_wren   = 1'b0;
   assign bus2.host_addr   = 8'h11;

   // Memory model: counts committed writes per address.
   always @(posedge clk) begin
      if (bus.s_wren) begin
         if (bus.s_addr == 8'h07) wr7 <= wr7 + 1;
         else if (bus.s_addr == 8'h05) wr5 <= wr5 + 1;
         else if (bus.s_addr == 8'h33) wr33 <= wr33 + 1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; start2 = 1'b0; key_in = '0; key_in2 = '0;
      bus.init_done = 0; bus.ksa_done = 0; bus.prga_done = 0;
      bus2.init_done = 0; bus2.ksa_done = 0; bus2.prga_done = 0;
      bus.host_addr = 8'h9C;
      step(); step();
      n_checks++; if ({busy, done, error} !== 3'b000) begin n_fail++; $display("FAIL rst_status: got %b want 000", {busy, done, error}); end
      n_checks++; if (key_out !== 24'h0) begin n_fail++; $display("FAIL rst_key: got %h want 000000", key_out); end
      n_checks++; if (eng_rst_n !== 1'b0) begin n_fail++; $display("FAIL rst_eng_rst_n: got %b want 0", eng_rst_n); end
      n_checks++; if ({bus.init_go, bus.ksa_go, bus.prga_go} !== 3'b000) begin n_fail++; $display("FAIL rst_go: got %b want 000", {bus.init_go, bus.ksa_go, bus.prga_go}); end
      n_checks++; if ({bus.s_addr, bus.s_wren} !== {8'h9C, 1'b0}) begin n_fail++; $display("FAIL rst_host: got %h/%b want 9c/0", bus.s_addr, bus.s_wren); end
      rst_n = 1'b1;
      #1;
      n_checks++; if (eng_rst_n !== 1'b0) begin n_fail++; $display("FAIL rel_eng_rst_n_pre: got %b want 0", eng_rst_n); end
      step();
      n_checks++; if (eng_rst_n !== 1'b1 || eng_rst_n2 !== 1'b1) begin n_fail++; $display("FAIL rel_eng_rst_n_post: got %b%b want 11", eng_rst_n, eng_rst_n2); end
   endtask

   task automatic test_full_run(input int ninit, input int nksa, input int nprga,
                                input logic [23:0] key, input bit mid_start);
      int b7, b5, b33;
      logic [7:0] h;
      bus.init_done = 0; bus.ksa_done = 0; bus.prga_done = 0;
      b7 = wr7; b5 = wr5; b33 = wr33;
      start = 1'b1; key_in = key;
      step();
      start = 1'b0; key_in = 24'($urandom);
      n_checks++; if ({busy, eng_rst_n, done, error} !== 4'b1000) begin n_fail++; $display("FAIL run_accept: busy/eng_rst_n/done/error got %b want 1000", {busy, eng_rst_n, done, error}); end
      n_checks++; if (key_out !== key) begin n_fail++; $display("FAIL run_key_latch: got %h want %h", key_out, key); end
      step();
      n_checks++; if ({eng_rst_n, bus.init_go, bus.s_wren, bus.s_addr} !== {3'b000, 8'h00}) begin n_fail++; $display("FAIL run_erst: got %b%b%b/%h want 000/00", eng_rst_n, bus.init_go, bus.s_wren, bus.s_addr); end
      step();
      n_checks++; if ({eng_rst_n, bus.init_go, bus.ksa_go} !== 3'b110) begin n_fail++; $display("FAIL run_init_entry: got %b want 110", {eng_rst_n, bus.init_go, bus.ksa_go}); end
      n_checks++; if ({bus.s_addr, bus.s_wren} !== {8'h07, 1'b1}) begin n_fail++; $display("FAIL run_init_mux: got %h/%b want 07/1", bus.s_addr, bus.s_wren); end
      repeat (ninit - 1) step();
      bus.init_done = 1'b1;
      step();
      n_checks++; if ({bus.ksa_go, bus.prga_go} !== 2'b10) begin n_fail++; $display("FAIL run_ksa_entry: got %b want 10", {bus.ksa_go, bus.prga_go}); end
      n_checks++; if (wr7 - b7 != ninit || wr5 - b5 != 0) begin n_fail++; $display("FAIL run_init_writes: got a7=%0d a5=%0d want a7=%0d a5=0", wr7 - b7, wr5 - b5, ninit); end
      for (int i = 1; i < nksa; i++) begin
         start = mid_start && (i == nksa / 2);
         if (start) key_in = 24'hFFFFFF;
         step();
      end
      start = 1'b0;
      n_checks++; if ({busy, bus.prga_go} !== 2'b10 || key_out !== key) begin n_fail++; $display("FAIL run_ksa_hold: busy/prga_go got %b key %h want 10 key %h", {busy, bus.prga_go}, key_out, key); end
      bus.ksa_done = 1'b1;
      step();
      n_checks++; if ({bus.prga_go, bus.s_addr} !== {1'b1, 8'h33} || wr5 - b5 != nksa) begin n_fail++; $display("FAIL run_prga_entry: go %b addr %h a5=%0d want 1/33/%0d", bus.prga_go, bus.s_addr, wr5 - b5, nksa); end
      repeat (nprga - 1) step();
      bus.prga_done = 1'b1;
      step();
      n_checks++; if ({done, busy, error, eng_rst_n} !== 4'b1001) begin n_fail++; $display("FAIL run_done: done/busy/error/eng_rst_n got %b want 1001", {done, busy, error, eng_rst_n}); end
      n_checks++; if ({bus.init_go, bus.ksa_go, bus.prga_go} !== 3'b111 || wr33 - b33 != nprga) begin n_fail++; $display("FAIL run_done_go: go %b a33=%0d want 111/%0d", {bus.init_go, bus.ksa_go, bus.prga_go}, wr33 - b33, nprga); end
      h = 8'($urandom);
      bus.host_addr = h;
      #1;
      n_checks++; if ({bus.s_addr, bus.s_wren} !== {h, 1'b0}) begin n_fail++; $display("FAIL run_done_host: got %h/%b want %h/0", bus.s_addr, bus.s_wren, h); end
   endtask

   task automatic test_host_in_done();
      bus.host_addr = 8'h2A;
      #1;
      n_checks++; if ({bus.s_addr, bus.s_wren} !== {8'h2A, 1'b0}) begin n_fail++; $display("FAIL host_2a: got %h/%b want 2a/0", bus.s_addr, bus.s_wren); end
   endtask

   task automatic test_foreign_done();
      bus.init_done = 0; bus.ksa_done = 1; bus.prga_done = 1;
      start = 1'b1; key_in = 24'($urandom);
      step();
      start = 1'b0;
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL fd_done_clear: got %b want 0", done); end
      repeat (2 + 5) step();
      n_checks++; if ({bus.init_go, bus.ksa_go, bus.prga_go, busy} !== 4'b1001) begin n_fail++; $display("FAIL fd_stay_init: got %b want 1001", {bus.init_go, bus.ksa_go, bus.prga_go, busy}); end
      bus.init_done = 1'b1;
      step();
      step();
      step();
      n_checks++; if ({done, busy} !== 2'b10) begin n_fail++; $display("FAIL fd_chain: done/busy got %b want 10", {done, busy}); end
   endtask

   task automatic test_timeout();
      int ni, k;
      start2 = 1'b1; key_in2 = 24'($urandom);
      step();
      start2 = 1'b0;
      step(); step();
      ni = $urandom_range(1, 40);
      repeat (ni - 1) step();
      bus2.init_done = 1'b1;
      step();
      n_checks++; if (bus2.ksa_go !== 1'b1) begin n_fail++; $display("FAIL to_ksa_entry: got %b want 1", bus2.ksa_go); end
      k = 201;
      for (int i = 1; i <= 200; i++) begin
         step();
         if (error2 === 1'b1) begin k = i; break; end
      end
      n_checks++; if (k != 64) begin n_fail++; $display("FAIL to_latency: got %0d want 64", k); end
      n_checks++; if ({error2, eng_rst_n2, busy2, done2} !== 4'b1000) begin n_fail++; $display("FAIL to_err_status: got %b want 1000", {error2, eng_rst_n2, busy2, done2}); end
      n_checks++; if ({bus2.init_go, bus2.ksa_go, bus2.prga_go} !== 3'b000) begin n_fail++; $display("FAIL to_err_go: got %b want 000", {bus2.init_go, bus2.ksa_go, bus2.prga_go}); end
      repeat (5) step();
      n_checks++; if ({error2, eng_rst_n2} !== 2'b10) begin n_fail++; $display("FAIL to_err_hold: got %b want 10", {error2, eng_rst_n2}); end
   endtask

   task automatic test_done_vs_timeout();
      bus2.init_done = 0; bus2.ksa_done = 0; bus2.prga_done = 0;
      start2 = 1'b1; key_in2 = 24'h00ABCD;
      step();
      start2 = 1'b0;
      n_checks++; if ({error2, busy2, key_out2} !== {2'b01, 24'h00ABCD}) begin n_fail++; $display("FAIL dvt_restart: err/busy %b key %h want 01 00abcd", {error2, busy2}, key_out2); end
      step(); step();
      bus2.init_done = 1'b1;
      step();
      repeat (63) step();
      n_checks++; if ({error2, bus2.prga_go} !== 2'b00) begin n_fail++; $display("FAIL dvt_pre_edge: got %b want 00", {error2, bus2.prga_go}); end
      bus2.ksa_done = 1'b1;
      step();
      n_checks++; if ({error2, bus2.prga_go, busy2} !== 3'b011) begin n_fail++; $display("FAIL dvt_done_wins: got %b want 011", {error2, bus2.prga_go, busy2}); end
      bus2.prga_done = 1'b1;
      step();
      n_checks++; if ({done2, error2} !== 2'b10) begin n_fail++; $display("FAIL dvt_finish: got %b want 10", {done2, error2}); end
   endtask

   task automatic test_reset_mid_prga();
      bus.init_done = 0; bus.ksa_done = 0; bus.prga_done = 0;
      bus.host_addr = 8'h6E;
      start = 1'b1; key_in = 24'h5A5A5A;
      step();
      start = 1'b0;
      step(); step();
      bus.init_done = 1'b1; step();
      bus.ksa_done = 1'b1; step();
      repeat (3) step();
      n_checks++; if (bus.prga_go !== 1'b1) begin n_fail++; $display("FAIL rmp_in_prga: got %b want 1", bus.prga_go); end
      rst_n = 1'b0;
      #1;
      n_checks++; if ({busy, done, error, eng_rst_n} !== 4'b0000 || key_out !== 24'h0) begin n_fail++; $display("FAIL rmp_async: status %b key %h want 0000 000000", {busy, done, error, eng_rst_n}, key_out); end
      n_checks++; if ({bus.init_go, bus.ksa_go, bus.prga_go, bus.s_wren, bus.s_addr} !== {4'b0000, 8'h6E}) begin n_fail++; $display("FAIL rmp_async_bus: go/wren %b addr %h want 0000 6e", {bus.init_go, bus.ksa_go, bus.prga_go, bus.s_wren}, bus.s_addr); end
      step();
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      test_reset();
      test_full_run(256, 2560, 300, 24'h000249, 1'b0);
      test_host_in_done();
      test_full_run($urandom_range(1, 30), $urandom_range(4, 40), $urandom_range(1, 30), 24'($urandom), 1'b1);
      test_foreign_done();
      test_timeout();
      test_done_vs_timeout();
      test_reset_mid_prga();
      test_full_run($urandom_range(1, 20), $urandom_range(4, 20), $urandom_range(1, 20), 24'($urandom), 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
